// File: rtl/ifetch_prefetch_buffer_if.sv
// Fetch-side bundle: core redirect, instruction-memory request/response, and
// the instruction handoff to the IF/ID register.
interface ifetch_prefetch_buffer_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data, instr_pc
    );
endinterface

// File: rtl/ifetch_prefetch_buffer.sv
// Sequential instruction prefetcher: keeps up to DEPTH words queued or in flight,
// flushes on redirect and drops responses belonging to the abandoned stream.
module ifetch_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      reset,
    ifetch_prefetch_buffer_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [31:0]   pcq        [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, pcq_rd, pcq_wr;
    logic [CW-1:0] count, inflight, discard;
    logic [CW:0]   occupancy;
    logic          redirect, req_fire, rsp_fire, push, pop;

    assign redirect  = bus.redirect_valid;
    assign occupancy = {1'b0, count} + {1'b0, inflight};

    // Counting in-flight requests against free slots guarantees every response lands.
    assign bus.imem_req_valid = reset && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.instr_valid    = (count != '0);
    assign bus.instr_data     = fifo_instr[rd_ptr];
    assign bus.instr_pc       = fifo_pc[rd_ptr];

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_fire = bus.imem_rsp_valid;
    assign push     = rsp_fire && (discard == '0) && !redirect;
    assign pop      = bus.instr_valid && bus.instr_ready && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pcq_rd   <= '0;
            pcq_wr   <= '0;
        end else begin
            inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
                pcq_wr   <= pcq_wr + 1'b1;
            end
            if (rsp_fire)
                pcq_rd <= pcq_rd + 1'b1;

            if (redirect) begin
                // A response in this very cycle is stale too, so it is not counted.
                fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                discard  <= inflight - CW'(rsp_fire);
            end else begin
                if (rsp_fire && (discard != '0))
                    discard <= discard - CW'(1);
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            pcq[pcq_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]    <= pcq[pcq_rd];
            fifo_instr[wr_ptr] <= bus.imem_rsp_data;
        end
    end

    a_rsp_needs_request: assert property (@(posedge clk) disable iff (!reset)
        bus.imem_rsp_valid |-> (inflight != '0));
    a_occupancy_bound: assert property (@(posedge clk) disable iff (!reset)
        occupancy <= (CW+1)'(DEPTH));
    a_discard_bound: assert property (@(posedge clk) disable iff (!reset)
        discard <= inflight);
endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Directed bench for ifetch_prefetch_buffer: cycle table for streaming/stall,
// plus hand-written redirect and mid-operation reset sequences.
module tb_ifetch_prefetch_buffer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ifetch_prefetch_buffer_if bus();

    ifetch_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    typedef struct {
        logic        rdy;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_iv;
        logic [31:0] exp_pc;
    } vec_t;

    pend_t       rspq[$];
    logic [31:0] fired_q[$];
    logic [31:0] delivered[$];
    vec_t        vt[10];
    int          cyc, lat, total, bad;
    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_pc, s_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive due response, sample outputs, take the edge, log fires.
    task automatic cycle();
        logic        fire;
        logic [31:0] faddr;
        if (rspq.size() > 0 && rspq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(rspq[0].addr);
            void'(rspq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        #1;
        fire   = bus.imem_req_valid && bus.imem_req_ready;
        faddr  = bus.imem_req_addr;
        s_rv   = bus.imem_req_valid;
        s_addr = bus.imem_req_addr;
        s_iv   = bus.instr_valid;
        s_pc   = bus.instr_pc;
        s_data = bus.instr_data;
        @(posedge clk);
        if (fire) begin
            rspq.push_back('{due: cyc + lat, addr: faddr});
            fired_q.push_back(faddr);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        rspq.delete();
        fired_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic watch_first(input int max, input string name, input logic [31:0] exp_pc);
        logic found = 1'b0;
        for (int n = 0; n < max && !found; n++) begin
            cycle();
            if (s_iv) begin
                found = 1'b1;
                chk({name, "_pc"}, s_pc, exp_pc);
                chk({name, "_data"}, s_data, mem_word(exp_pc));
            end
        end
        chk({name, "_seen"}, {31'b0, found}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic bad_200;
        total = 0;
        bad   = 0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        lat = 1;

        vt[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vt[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vt[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vt[3] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04};
        vt[4] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h04};
        vt[5] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h04};
        vt[6] = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h04};
        vt[7] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
        vt[8] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
        vt[9] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};

        // Outputs while held in reset.
        #1;
        chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);

        // Latency-1 streaming with a short stall, cycle by cycle.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.instr_ready = vt[i].rdy;
            cycle();
            chk($sformatf("t1_rv[%0d]", i), {31'b0, s_rv}, {31'b0, vt[i].exp_rv});
            chk($sformatf("t1_addr[%0d]", i), s_addr, vt[i].exp_addr);
            chk($sformatf("t1_iv[%0d]", i), {31'b0, s_iv}, {31'b0, vt[i].exp_iv});
            if (vt[i].exp_iv) begin
                chk($sformatf("t1_pc[%0d]", i), s_pc, vt[i].exp_pc);
                chk($sformatf("t1_data[%0d]", i), s_data, mem_word(vt[i].exp_pc));
            end
        end

        // Stalled from reset, latency 2: fill exactly DEPTH, then drain without bubbles.
        lat = 2;
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (8) cycle();
        chk("t2_fired", fired_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < fired_q.size(); i++)
            chk($sformatf("t2_addr[%0d]", i), fired_q[i], 32'(4 * i));
        chk("t2_rv_full", {31'b0, s_rv}, 32'd0);
        chk("t2_head_pc", s_pc, 32'h0);
        chk("t2_head_iv", {31'b0, s_iv}, 32'd1);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("t2_pop_iv[%0d]", i), {31'b0, s_iv}, 32'd1);
            chk($sformatf("t2_pop_pc[%0d]", i), s_pc, 32'(4 * i));
            chk($sformatf("t2_pop_data[%0d]", i), s_data, mem_word(32'(4 * i)));
        end
        repeat (2) cycle();
        chk("t2_resume_n", {31'b0, fired_q.size() > 4}, 32'd1);
        if (fired_q.size() > 4)
            chk("t2_resume_addr", fired_q[4], 32'h10);

        // Three requests in flight, redirect with no response in that cycle.
        lat = 4;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h20;
        cycle();
        bus.redirect_valid = 1'b0;
        repeat (3) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        cycle();
        chk("t3_rv_in_redirect", {31'b0, s_rv}, 32'd0);
        bus.redirect_valid = 1'b0;
        watch_first(20, "t3_first", 32'h100);
        chk("t3_fired_n", {31'b0, fired_q.size() >= 4}, 32'd1);
        if (fired_q.size() >= 4) begin
            chk("t3_fire2", fired_q[2], 32'h28);
            chk("t3_fire3", fired_q[3], 32'h100);
        end

        // Redirect coinciding with a response while two are in flight.
        lat = 2;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        cycle();
        bus.redirect_valid = 1'b0;
        repeat (2) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        cycle();
        bus.redirect_valid = 1'b0;
        watch_first(20, "t4_first", 32'h80);

        // Back-to-back redirects while streaming: only the second stream survives.
        lat = 1;
        do_reset();
        repeat (4) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        cycle();
        bus.redirect_pc    = 32'h300;
        cycle();
        chk("t5_iv_after_redirect", {31'b0, s_iv}, 32'd0);
        chk("t5_rv_in_redirect", {31'b0, s_rv}, 32'd0);
        bus.redirect_valid = 1'b0;
        delivered.delete();
        bad_200 = 1'b0;
        repeat (12) begin
            cycle();
            if (s_iv) begin
                if (s_pc[31:8] == 24'h2) bad_200 = 1'b1;
                delivered.push_back(s_pc);
            end
        end
        chk("t5_no_0x200", {31'b0, bad_200}, 32'd0);
        chk("t5_delivered_n", {31'b0, delivered.size() >= 3}, 32'd1);
        for (int i = 0; i < 3 && i < delivered.size(); i++)
            chk($sformatf("t5_pc[%0d]", i), delivered[i], 32'h300 + 32'(4 * i));

        // Reset mid-operation with count=2, inflight=2.
        lat = 2;
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (4) cycle();
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t6_pre_iv", {31'b0, bus.instr_valid}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_async_iv", {31'b0, bus.instr_valid}, 32'd0);
        chk("t6_async_rv", {31'b0, bus.imem_req_valid}, 32'd0);
        rspq.delete();
        fired_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        lat   = 1;
        bus.instr_ready = 1'b1;
        watch_first(10, "t6_first", 32'h0);
        chk("t6_fired_n", {31'b0, fired_q.size() > 0}, 32'd1);
        if (fired_q.size() > 0)
            chk("t6_first_addr", fired_q[0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
